// File: rtl/sync_capture_pkg.sv
// sync_capture_pkg
//   Shared definitions for the capture controller.
//   - state_t     : controller state encoding (IDLE / SETTLE / PRESENT)
//   - DEF_*       : default parameter values for sync_capture_ctrl
package sync_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH    = 4;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_SETTLE_CYCLES = 4;

endpackage

// File: rtl/sync_capture_ctrl_pipeline.sv
// pipeline
//   Multi-stage flop synchronizer for a DATA_WIDTH word. The word is shifted
//   through SYNC_STAGES flops; q follows d after SYNC_STAGES rising edges.
//   Individual bits may resolve on different edges, which is why the
//   controller above only commits a word after it has stayed stable.
// Ports:
//   clk  in   single clock
//   rst  in   synchronous active-high reset, clears every stage to 0
//   d    in   asynchronous input word
//   q    out  synchronized word (last stage)
module pipeline #(
    parameter int DATA_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] stg;

    always_ff @(posedge clk) begin
        if (rst) stg[0] <= '0;
        else     stg[0] <= d;
    end

    for (genvar k = 1; k < SYNC_STAGES; k++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) stg[k] <= '0;
            else     stg[k] <= stg[k-1];
        end
    end

    assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/sync_capture_ctrl.sv
// sync_capture_ctrl
//   Synchronizes an asynchronous multi-bit word, waits until the synchronized
//   value has been identical for SETTLE_CYCLES consecutive samples, commits it
//   and offers it downstream on a valid/ready handshake.
//   Optional build macro SYNC_CAPTURE_OVERRUN_EN adds a sticky overrun flag,
//   set whenever the synchronized input differs from the word still waiting
//   for acceptance.
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   async_in   in   asynchronous input word
//   out_ready  in   downstream accepts out_data when high with out_valid
//   out_data   out  last committed word
//   out_valid  out  committed word pending acceptance
//   busy       out  high while a candidate is settling
//   overrun    out  (SYNC_CAPTURE_OVERRUN_EN only) sticky input-change-while-presenting
module sync_capture_ctrl
    import sync_capture_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] async_in,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  busy
`ifdef SYNC_CAPTURE_OVERRUN_EN
    ,
    output logic                  overrun
`endif
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [DATA_WIDTH-1:0] sync_w;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] cand_q, cand_d;
    logic [DATA_WIDTH-1:0] comm_q, comm_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  vld_q, vld_d;

    pipeline #(
        .SYNC_STAGES(SYNC_STAGES),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pipeline (
        .clk(clk),
        .rst(rst),
        .d  (async_in),
        .q  (sync_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            comm_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            comm_q  <= comm_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        comm_d  = comm_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        case (state_q)
            ST_IDLE: begin
                if (sync_w != comm_q) begin
                    if (SETTLE_CYCLES == 1) begin
                        // A single sample is already enough to commit.
                        comm_d  = sync_w;
                        data_d  = sync_w;
                        vld_d   = 1'b1;
                        state_d = ST_PRESENT;
                    end else begin
                        cand_d  = sync_w;
                        cnt_d   = CNT_ONE;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (sync_w == comm_q) begin
                    // Input went back to the committed word: nothing new.
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (sync_w != cand_q) begin
                    // Still moving: restart the stability count on the new value.
                    cand_d = sync_w;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q == CNT_LAST) begin
                    comm_d  = cand_q;
                    data_d  = cand_q;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_PRESENT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESENT: begin
                // Input is deliberately ignored until the word is taken.
                if (vld_q && out_ready) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    assign out_data  = data_q;
    assign out_valid = vld_q;
    assign busy      = (state_q == ST_SETTLE);

`ifdef SYNC_CAPTURE_OVERRUN_EN
    logic ovr_q;

    always_ff @(posedge clk) begin
        if (rst)
            ovr_q <= 1'b0;
        else if (state_q == ST_PRESENT && sync_w != data_q)
            ovr_q <= 1'b1;
    end

    assign overrun = ovr_q;
`endif

endmodule
